// File: rtl/multi_blink.sv
// Multi-channel LED pattern generator: one shared tick prescaler feeding
// independent per-channel OFF/ON/BLINK/BURST engines configured by a write port.
module multi_blink #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int NUM_LEDS = 8,
    parameter int DIV_W    = 16,
    parameter int BURST_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [DIV_W-1:0]    cfg_half_period,
    input  logic [BURST_W-1:0]  cfg_burst,
    output logic [NUM_LEDS-1:0] leds,
    output logic [NUM_LEDS-1:0] burst_done,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    localparam int TICK_DIV_RAW = CLK_FREQ / TICK_HZ;
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int PS_W         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        tick_d   = (ps_cnt_q == PS_LAST);
        ps_cnt_d = tick_d ? '0 : ps_cnt_q + PS_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        mode_t              mode_q, mode_d;
        logic [DIV_W-1:0]   phase_q, phase_d;
        logic [DIV_W-1:0]   half_q, half_d;
        logic [BURST_W-1:0] rem_q, rem_d;
        logic               led_q, led_d;
        logic               done_q, done_d;
        logic               sel;

        // Out-of-range channel indices simply never match any channel.
        assign sel = cfg_we && (cfg_ch == 4'(gi));

        always_comb begin
            mode_d  = mode_q;
            phase_d = phase_q;
            half_d  = half_q;
            rem_d   = rem_q;
            led_d   = led_q;
            done_d  = 1'b0;
            if (sel) begin
                phase_d = '0;
                half_d  = (cfg_half_period == '0) ? DIV_W'(1) : cfg_half_period;
                rem_d   = '0;
                case (mode_t'(cfg_mode))
                    MODE_OFF: begin
                        mode_d = MODE_OFF;
                        led_d  = 1'b0;
                    end
                    MODE_ON: begin
                        mode_d = MODE_ON;
                        led_d  = 1'b1;
                    end
                    MODE_BLINK: begin
                        mode_d = MODE_BLINK;
                        led_d  = 1'b1;
                    end
                    MODE_BURST: begin
                        if (cfg_burst == '0) begin
                            mode_d = MODE_OFF;
                            led_d  = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            mode_d = MODE_BURST;
                            led_d  = 1'b1;
                            rem_d  = cfg_burst;
                        end
                    end
                endcase
            end else if (tick_q && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
                if (phase_q == half_q - DIV_W'(1)) begin
                    phase_d = '0;
                    led_d   = ~led_q;
                    // Bursts count falling edges and stop right on the last one.
                    if (led_q && mode_q == MODE_BURST) begin
                        rem_d = rem_q - BURST_W'(1);
                        if (rem_q == BURST_W'(1)) begin
                            mode_d = MODE_OFF;
                            done_d = 1'b1;
                        end
                    end
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_q  <= MODE_OFF;
                phase_q <= '0;
                half_q  <= DIV_W'(1);
                rem_q   <= '0;
                led_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                phase_q <= phase_d;
                half_q  <= half_d;
                rem_q   <= rem_d;
                led_q   <= led_d;
                done_q  <= done_d;
            end
        end

        assign leds[gi]       = led_q;
        assign burst_done[gi] = done_q;
    end

endmodule

// File: tb/tb_multi_blink.sv
// Bench for multi_blink: cycle scoreboard against a behavioural model, a table of
// config writes with hand-derived LED results, and multi-cycle corner sequences.
module tb_multi_blink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_half_period = '0;
    logic [3:0]  cfg_burst = '0;
    logic [7:0]  leds;
    logic [7:0]  burst_done;
    logic        tick;

    multi_blink #(
        .CLK_FREQ(100), .TICK_HZ(10), .NUM_LEDS(8), .DIV_W(16), .BURST_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half_period(cfg_half_period),
        .cfg_burst(cfg_burst), .leds(leds), .burst_done(burst_done), .tick(tick)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_checks = 0;

    typedef struct {
        logic [7:0] leds;
        logic [7:0] done;
        logic       tick;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic       we;
        logic [3:0] ch;
        logic [1:0] mode;
        logic [15:0] hp;
        logic [3:0] burst;
        logic [7:0] exp_leds;
        logic [7:0] exp_done;
    } vec_t;
    vec_t vecs[10];

    // Behavioural reference state
    int       m_cnt;
    bit       m_tick;
    int       m_mode[8];
    int       m_phase[8];
    int       m_half[8];
    int       m_rem[8];
    bit [7:0] m_led;
    bit [7:0] m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_tick = 0; m_led = '0; m_done = '0;
        for (int c = 0; c < 8; c++) begin
            m_mode[c] = 0; m_phase[c] = 0; m_half[c] = 1; m_rem[c] = 0;
        end
    endtask

    task automatic model_advance();
        bit tn;
        tn = (m_cnt == 9);
        m_cnt = tn ? 0 : m_cnt + 1;
        for (int c = 0; c < 8; c++) begin
            m_done[c] = 0;
            if (cfg_we && int'(cfg_ch) == c) begin
                m_phase[c] = 0;
                m_half[c] = (cfg_half_period == 0) ? 1 : int'(cfg_half_period);
                m_rem[c] = 0;
                case (cfg_mode)
                    2'd0: begin m_mode[c] = 0; m_led[c] = 0; end
                    2'd1: begin m_mode[c] = 1; m_led[c] = 1; end
                    2'd2: begin m_mode[c] = 2; m_led[c] = 1; end
                    default: begin
                        if (cfg_burst == 0) begin
                            m_mode[c] = 0; m_led[c] = 0; m_done[c] = 1;
                        end else begin
                            m_mode[c] = 3; m_led[c] = 1; m_rem[c] = int'(cfg_burst);
                        end
                    end
                endcase
            end else if (m_tick && m_mode[c] >= 2) begin
                if (m_phase[c] + 1 == m_half[c]) begin
                    m_phase[c] = 0;
                    if (m_led[c]) begin
                        m_led[c] = 0;
                        if (m_mode[c] == 3) begin
                            if (m_rem[c] == 1) begin
                                m_mode[c] = 0; m_done[c] = 1;
                            end
                            m_rem[c]--;
                        end
                    end else begin
                        m_led[c] = 1;
                    end
                end else begin
                    m_phase[c]++;
                end
            end
        end
        m_tick = tn;
    endtask

    // One clock: predict, push, clock, pop and compare.
    task automatic step();
        exp_t e;
        model_advance();
        e.leds = m_led; e.done = m_done; e.tick = m_tick;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("cycle", {15'd0, leds, burst_done, tick}, {15'd0, e.leds, e.done, e.tick});
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [1:0] mode,
                             input logic [15:0] hp, input logic [3:0] burst);
        cfg_ch = ch; cfg_mode = mode; cfg_half_period = hp; cfg_burst = burst;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
    endtask

    // Step until tick is seen high; leaves the bench in the tick-high cycle.
    task automatic align_to_tick(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (tick) found = 1;
        end
        check(name, {31'd0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, prev, t_last, n_tog, first_tog, rise_at, falls, rises, dones, done_at, last_fall, bad;

        vecs[0] = '{1'b1, 4'd0,  2'd1, 16'd0,   4'd0, 8'h01, 8'h00};
        vecs[1] = '{1'b0, 4'd0,  2'd0, 16'd0,   4'd0, 8'h01, 8'h00};
        vecs[2] = '{1'b1, 4'd1,  2'd2, 16'd100, 4'd0, 8'h03, 8'h00};
        vecs[3] = '{1'b1, 4'd7,  2'd3, 16'd100, 4'd2, 8'h83, 8'h00};
        vecs[4] = '{1'b1, 4'd9,  2'd1, 16'd1,   4'd0, 8'h83, 8'h00};
        vecs[5] = '{1'b1, 4'd15, 2'd1, 16'd1,   4'd0, 8'h83, 8'h00};
        vecs[6] = '{1'b1, 4'd0,  2'd0, 16'd1,   4'd0, 8'h82, 8'h00};
        vecs[7] = '{1'b1, 4'd5,  2'd3, 16'd4,   4'd0, 8'h82, 8'h20};
        vecs[8] = '{1'b1, 4'd7,  2'd0, 16'd1,   4'd0, 8'h02, 8'h00};
        vecs[9] = '{1'b1, 4'd1,  2'd0, 16'd1,   4'd0, 8'h00, 8'h00};

        // Reset and idle: tick once every 10 cycles
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check("reset_leds", {24'd0, leds}, 32'd0);
        check("reset_done", {24'd0, burst_done}, 32'd0);
        check("reset_tick", {31'd0, tick}, 32'd0);
        ticks = 0; t_last = -1; bad = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (tick) begin
                ticks++;
                if (t_last >= 0 && i - t_last != 10) bad++;
                t_last = i;
            end
        end
        check("idle_tick_count", ticks, 5);
        check("idle_tick_period_errs", bad, 0);
        check("idle_leds", {24'd0, leds}, 32'd0);

        // Table of single writes with the LED state right after each write
        for (int v = 0; v < 10; v++) begin
            cfg_ch = vecs[v].ch; cfg_mode = vecs[v].mode;
            cfg_half_period = vecs[v].hp; cfg_burst = vecs[v].burst;
            cfg_we = vecs[v].we;
            step();
            cfg_we = 1'b0;
            check($sformatf("vec%0d_leds", v), {24'd0, leds}, {24'd0, vecs[v].exp_leds});
            check($sformatf("vec%0d_done", v), {24'd0, burst_done}, {24'd0, vecs[v].exp_done});
        end

        // BLINK half_period=2: 20-cycle halves
        cfg_write(4'd0, 2'd2, 16'd2, 4'd0);
        check("blink_start", {24'd0, leds}, 32'h01);
        prev = leds[0]; n_tog = 0; t_last = -1; first_tog = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (int'(leds[0]) != prev) begin
                if (t_last >= 0) check("blink_half_len", i - t_last, 20);
                else first_tog = i;
                t_last = i; n_tog++;
                prev = leds[0];
            end
        end
        check("blink_toggles", {31'd0, n_tog >= 5}, 32'd1);
        check("blink_first_in_range", {31'd0, first_tog >= 11 && first_tog <= 20}, 32'd1);
        cfg_write(4'd0, 2'd0, 16'd1, 4'd0);

        // BURST of 3 with half_period=1, written just after a tick
        align_to_tick("burst_align");
        cfg_write(4'd3, 2'd3, 16'd1, 4'd3);
        check("burst_start", {24'd0, leds}, 32'h08);
        prev = 1; rise_at = 0; falls = 0; rises = 0; dones = 0; done_at = -1; last_fall = -2;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (prev == 1 && leds[3] == 1'b0) begin
                check("burst_hi_len", i - rise_at, 10);
                falls++; last_fall = i;
            end
            if (prev == 0 && leds[3] == 1'b1) begin
                rise_at = i; rises++;
            end
            if (burst_done[3]) begin
                dones++; done_at = i;
            end
            prev = leds[3];
        end
        check("burst_falls", falls, 3);
        check("burst_rises", rises, 2);
        check("burst_done_count", dones, 1);
        check("burst_done_align", done_at, last_fall);
        check("burst_end_leds", {24'd0, leds}, 32'd0);

        // Zero-count burst pulses done for exactly one cycle
        cfg_write(4'd5, 2'd3, 16'd3, 4'd0);
        check("burst0_done", {24'd0, burst_done}, 32'h20);
        step();
        check("burst0_done_clear", {24'd0, burst_done}, 32'd0);

        // Write beats tick on ch1; ch0 still toggles on that tick
        cfg_write(4'd0, 2'd2, 16'd1, 4'd0);
        cfg_write(4'd1, 2'd2, 16'd1, 4'd0);
        align_to_tick("collide_align");
        prev = leds[0];
        cfg_write(4'd1, 2'd1, 16'd1, 4'd0);
        check("collide_ch1_on", {31'd0, leds[1]}, 32'd1);
        check("collide_ch0_toggled", {31'd0, leds[0]}, {31'd0, ~prev[0]});
        bad = 0; n_tog = 0; prev = leds[0];
        for (int i = 1; i <= 40; i++) begin
            step();
            if (leds[1] != 1'b1) bad++;
            if (int'(leds[0]) != prev) begin
                n_tog++; prev = leds[0];
            end
        end
        check("collide_ch1_held", bad, 0);
        check("collide_ch0_toggles", n_tog, 4);

        // All channels bursting, then asynchronous reset mid-cycle
        for (int c = 0; c < 8; c++) cfg_write(4'(c), 2'd3, 16'd50, 4'd15);
        repeat (20) step();
        check("all_burst_leds", {24'd0, leds}, 32'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_leds", {24'd0, leds}, 32'd0);
        check("async_rst_done", {24'd0, burst_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        dones = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (burst_done != 8'h00) dones++;
        end
        check("post_rst_no_done", dones, 0);
        check("post_rst_leds", {24'd0, leds}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
